// File: rtl/data_memory.sv
// Byte-addressable data memory for the MIPS datapath: lane-masked synchronous stores, combinational extending loads.
// Latency: stores commit at the clk edge, loads are zero-cycle; no backpressure (a bad access is dropped and flagged).
module data_memory #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [1:0]  size,
    input  logic        ld_unsigned,
    input  logic        err_clr,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        err_sticky
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [31:0]           mem [DEPTH];
    logic [ADDR_WIDTH-1:0] widx;
    logic [1:0]            lane;
    logic [3:0]            byte_en;
    logic [31:0]           wdata_rep;
    logic [31:0]           rword;
    logic [31:0]           rshift;
    logic [15:0]           rhalf;
    logic [7:0]            rbyte;
    logic                  unused_addr;

    // Address bits above the array wrap around silently.
    assign widx        = addr[ADDR_WIDTH+1:2];
    assign lane        = addr[1:0];
    assign unused_addr = ^addr[31:ADDR_WIDTH+2];

    assign misaligned = (mem_read | mem_write) &
                        (((size == 2'b01) & addr[0]) |
                         ((size == 2'b10) & (lane != 2'b00)) |
                         (size == 2'b11));

    always_comb begin
        byte_en   = 4'b0000;
        wdata_rep = wdata;
        case (size)
            2'b00: begin
                byte_en[lane] = 1'b1;
                wdata_rep     = {4{wdata[7:0]}};
            end
            2'b01: begin
                byte_en   = addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            2'b10:   byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_write && !misaligned) begin
            for (int k = 0; k < 4; k++) begin
                if (byte_en[k]) begin
                    mem[widx][8*k +: 8] <= wdata_rep[8*k +: 8];
                end
            end
        end
    end

    // Set wins over clear so an error in the clearing cycle is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
        end else if (misaligned) begin
            err_sticky <= 1'b1;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
        end
    end

    assign rword  = mem[widx];
    assign rshift = rword >> {lane, 3'b000};
    assign rbyte  = rshift[7:0];
    assign rhalf  = addr[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        rdata = '0;
        if (rst_n && mem_read && !misaligned) begin
            case (size)
                2'b00:   rdata = ld_unsigned ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
                2'b01:   rdata = ld_unsigned ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
                2'b10:   rdata = rword;
                default: rdata = '0;
            endcase
        end
    end
endmodule
